// File: rtl/mem_pkg.sv
// mem_pkg: shared RV32I load/store funct3 encodings and memory FSM states.
// Exports: F3_* funct3 constants, state_e, f3_legal(we, f3).
package mem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;
   // Stores have no unsigned variants, so only B/H/W are legal with we=1.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      return (f3 == F3_B || f3 == F3_H || f3 == F3_W) || (!we && (f3 == F3_BU || f3 == F3_HU));
   endfunction
endpackage

// File: rtl/data_memory_load_align.sv
// load_align: picks the addressed byte/halfword lane of a RAM word and extends it.
// Ports: word (raw RAM word), f3 (load funct3), off (addr[1:0]) -> data (extended result).
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  f3,
   input  logic [1:0]  off,
   output logic [31:0] data
);
   logic [31:0] b_sh, h_sh;
   always_comb begin
      b_sh = word >> {off, 3'b000};
      h_sh = word >> {off[1], 4'b0000};
      data = f3 == F3_B  ? {{24{b_sh[7]}}, b_sh[7:0]} :
             f3 == F3_BU ? {24'b0, b_sh[7:0]} :
             f3 == F3_H  ? {{16{h_sh[15]}}, h_sh[15:0]} :
             f3 == F3_HU ? {16'b0, h_sh[15:0]} : word;
   end
endmodule

// File: rtl/data_memory.sv
// data_memory: single-port 32-bit data RAM with RV32I byte/half/word access and wait states.
// Ports: clk, reset (sync, active-low); request req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata;
// response resp_valid (1-cycle strobe), resp_rdata (extended load data), resp_err.
module data_memory
   import mem_pkg::*;
#(
   parameter int DEPTH       = 16384,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d, rv_q, rv_d, err_q, err_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, al;
   logic        idle, acc, go, c_we, c_err;
   logic [2:0]  c_f3;
   logic [31:0] c_addr, c_wdata, wd;
   logic [3:0]  be;
   logic [AW-1:0] idx;
   logic [31:0] mem [DEPTH];
   assign req_ready = reset && state_q == S_IDLE;
   assign acc = req_valid && req_ready;
   always_comb begin
      idle = state_q == S_IDLE;
      // With no wait states the access happens on the accept edge itself, so use the live request.
      c_we = idle ? req_we : we_q;
      c_f3 = idle ? req_funct3 : f3_q;
      c_addr = idle ? req_addr : addr_q;
      c_wdata = idle ? req_wdata : wdata_q;
      c_err = !f3_legal(c_we, c_f3) || (c_f3[1:0] == 2'b01 && c_addr[0]) ||
              (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= 32'(DEPTH));
      go = WAIT_STATES == 0 ? acc : (reset && state_q == S_WAIT && cnt_q == 4'd1);
      be = c_f3[1:0] == 2'b00 ? 4'b0001 << c_addr[1:0] :
           c_f3[1:0] == 2'b01 ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wd = c_f3[1:0] == 2'b00 ? {4{c_wdata[7:0]}} :
           c_f3[1:0] == 2'b01 ? {2{c_wdata[15:0]}} : c_wdata;
      idx = c_addr[AW+1:2];
      state_d = state_q;
      cnt_d = cnt_q;
      we_d = we_q;
      f3_d = f3_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      if (acc) begin
         we_d = req_we;
         f3_d = req_funct3;
         addr_d = req_addr;
         wdata_d = req_wdata;
         cnt_d = 4'(WAIT_STATES);
         state_d = WAIT_STATES == 0 ? S_RESP : S_WAIT;
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q - 4'd1;
         state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
      end else if (state_q == S_RESP) begin
         state_d = S_IDLE;
      end
      rv_d = go;
      err_d = go && c_err;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q <= 4'd0;
         we_q <= 1'b0;
         f3_q <= 3'd0;
         addr_q <= 32'd0;
         wdata_q <= 32'd0;
         rv_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         we_q <= we_d;
         f3_q <= f3_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rv_q <= rv_d;
         err_q <= err_d;
      end
   end
   // RAM contents survive reset; the single access per request happens on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (go) begin
         rd_q <= mem[idx];
         for (int i = 0; i < 4; i++)
            if (c_we && !c_err && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
   end
   load_align u_align (.word(rd_q), .f3(f3_q), .off(addr_q[1:0]), .data(al));
   assign resp_valid = rv_q;
   assign resp_err = err_q;
   assign resp_rdata = (rv_q && !err_q && !we_q) ? al : 32'd0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed checks of data_memory with a byte-level reference model (WAIT_STATES 0 and 3).
module tb_data_memory;
   import mem_pkg::*;
   localparam int D0 = 16384;
   localparam int D3 = 64;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst0_n, v0, we0, rdy0, rv0, er0;
   logic [2:0] f0;
   logic [31:0] a0, w0, rd0;
   logic rst3_n, v3, we3, rdy3, rv3, er3;
   logic [2:0] f3s;
   logic [31:0] a3, w3, rd3;
   data_memory #(.DEPTH(D0), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(rst0_n), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
      .req_funct3(f0), .req_addr(a0), .req_wdata(w0),
      .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0));
   data_memory #(.DEPTH(D3), .WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(rst3_n), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
      .req_funct3(f3s), .req_addr(a3), .req_wdata(w3),
      .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3));
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int vectors = 0;
   int miscompares = 0;
   bit cmp_on = 1'b0;
   logic [7:0]  mb [int];
   logic [31:0] exp_rd [int];
   logic        exp_er [int];
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask
   // Reference: memory as individual bytes, access size from funct3, plain arithmetic for alignment.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int n;
      logic legal;
      logic [31:0] v;
      n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      er = !legal || (a % n) != 0 || (a / 4) >= D0;
      rd = 32'd0;
      v = 32'd0;
      if (!er) begin
         for (int k = 0; k < n; k++)
            if (we) mb[int'(a) + k] = wd[8*k +: 8];
            else v[8*k +: 8] = mb[int'(a) + k];
         if (!we) rd = (n == 4 || f3[2]) ? v : n == 1 ? {{24{v[7]}}, v[7:0]} : {{16{v[15]}}, v[15:0]};
      end
   endfunction
   always @(negedge clk) begin
      if (cmp_on) begin
         logic ev, eer;
         logic [31:0] erd;
         ev = exp_rd.exists(cyc);
         erd = ev ? exp_rd[cyc] : 32'd0;
         eer = ev ? exp_er[cyc] : 1'b0;
         vectors++;
         if ({rv0, rd0, er0} !== {ev, erd, eer}) begin
            miscompares++;
            $display("FAIL resp@%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b", cyc, rv0, rd0, er0, ev, erd, eer);
         end
      end
   end
   task automatic do0(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] lit_rd, input logic lit_er);
      int n, c;
      logic [31:0] mrd;
      logic mer;
      n = 0;
      while (!rdy0 && n < 8) begin @(negedge clk); n++; end
      chk({nm, " ready"}, {31'd0, rdy0}, 32'd1);
      v0 = 1'b1; we0 = we; f0 = f3; a0 = a; w0 = wd;
      c = cyc;
      model(we, f3, a, wd, mrd, mer);
      exp_rd[c + 1] = mrd;
      exp_er[c + 1] = mer;
      chk({nm, " model data"}, mrd, lit_rd);
      chk({nm, " model err"}, {31'd0, mer}, {31'd0, lit_er});
      @(negedge clk);
      v0 = 1'b0; we0 = 1'($urandom); f0 = 3'($urandom); a0 = $urandom; w0 = $urandom;
      n = 0;
      while (!rv0 && n < 6) begin @(negedge clk); n++; end
      chk({nm, " latency"}, 32'(cyc - c), 32'd1);
      chk({nm, " rdata"}, rd0, lit_rd);
      chk({nm, " err"}, {31'd0, er0}, {31'd0, lit_er});
   endtask
   task automatic do3(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
      int n, c;
      n = 0;
      while (!rdy3 && n < 12) begin @(negedge clk); n++; end
      v3 = 1'b1; we3 = we; f3s = f3; a3 = a; w3 = wd;
      c = cyc;
      @(negedge clk);
      v3 = 1'b0; a3 = $urandom; w3 = $urandom;
      n = 0;
      while (!rv3 && n < 10) begin @(negedge clk); n++; end
      lat = cyc - c;
      rd = rd3;
      er = er3;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int lat, c;
      logic [31:0] rd;
      logic er;
      rst0_n = 1'b0; rst3_n = 1'b0;
      v0 = 1'b1; we0 = 1'b0; f0 = 3'd2; a0 = 32'h0; w0 = 32'h0;
      v3 = 1'b1; we3 = 1'b0; f3s = 3'd2; a3 = 32'h0; w3 = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset ready0", {31'd0, rdy0}, 32'd0);
      chk("reset ready3", {31'd0, rdy3}, 32'd0);
      chk("reset resp0", {31'd0, rv0, er0}, 32'd0);
      chk("reset rdata0", rd0, 32'd0);
      chk("reset resp3", {31'd0, rv3, er3}, 32'd0);
      v0 = 1'b0; v3 = 1'b0;
      rst0_n = 1'b1; rst3_n = 1'b1;
      cmp_on = 1'b1;
      @(negedge clk);
      do0("SW 10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      do0("LW 10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      do0("LB 13", 1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
      do0("LBU 13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 1'b0);
      do0("LH 10", 1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
      do0("LHU 12", 1'b0, 3'd5, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
      do0("SB 11", 1'b1, 3'd0, 32'h11, 32'h00000055, 32'h0, 1'b0);
      do0("LW 10 sb", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
      do0("LW 12 misal", 1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1);
      do0("SH 11 misal", 1'b1, 3'd1, 32'h11, 32'h00001234, 32'h0, 1'b1);
      do0("LW oor", 1'b0, 3'd2, 32'(4 * D0), 32'h0, 32'h0, 1'b1);
      do0("SW oor", 1'b1, 3'd2, 32'(4 * D0), 32'h12345678, 32'h0, 1'b1);
      do0("st f3=4", 1'b1, 3'd4, 32'h10, 32'h0, 32'h0, 1'b1);
      do0("ld f3=3", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1);
      do0("LW 10 kept", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
      do0("SW 14", 1'b1, 3'd2, 32'h14, 32'h01020304, 32'h0, 1'b0);
      do0("SH 16", 1'b1, 3'd1, 32'h16, 32'hCAFE8001, 32'h0, 1'b0);
      do0("LW 14", 1'b0, 3'd2, 32'h14, 32'h0, 32'h80010304, 1'b0);
      do0("LH 16", 1'b0, 3'd1, 32'h16, 32'h0, 32'hFFFF8001, 1'b0);
      do0("LBU 15", 1'b0, 3'd4, 32'h15, 32'h0, 32'h00000003, 1'b0);
      do0("SW top", 1'b1, 3'd2, 32'(4 * D0 - 4), 32'h0BADF00D, 32'h0, 1'b0);
      do0("LW top", 1'b0, 3'd2, 32'(4 * D0 - 4), 32'h0, 32'h0BADF00D, 1'b0);
      // Three wait states: timing of ready/valid relative to accept.
      v3 = 1'b1; we3 = 1'b1; f3s = 3'd2; a3 = 32'h8; w3 = 32'h11223344;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) begin v3 = 1'b0; a3 = 32'h4; w3 = $urandom; end
         chk($sformatf("ws3 ready c%0d", k), {31'd0, rdy3}, {31'd0, k == 5});
         chk($sformatf("ws3 valid c%0d", k), {31'd0, rv3}, {31'd0, k == 4});
         chk($sformatf("ws3 out c%0d", k), rd3 | {31'd0, er3}, 32'd0);
      end
      // Reset during WAIT abandons the store.
      v3 = 1'b1; we3 = 1'b1; f3s = 3'd2; a3 = 32'h8; w3 = 32'hAAAAAAAA;
      @(negedge clk);
      v3 = 1'b0;
      @(negedge clk);
      rst3_n = 1'b0;
      @(negedge clk);
      chk("rst mid ready", {31'd0, rdy3}, 32'd0);
      @(negedge clk);
      chk("rst idle ready", {31'd0, rdy3}, 32'd0);
      rst3_n = 1'b1;
      c = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (rv3) c++;
      end
      chk("rst no resp", 32'(c), 32'd0);
      do3(1'b0, 3'd2, 32'h8, 32'h0, lat, rd, er);
      chk("ws3 LW latency", 32'(lat), 32'd4);
      chk("ws3 LW unchanged", rd, 32'h11223344);
      chk("ws3 LW err", {31'd0, er}, 32'd0);
      do3(1'b0, 3'd0, 32'hB, 32'h0, lat, rd, er);
      chk("ws3 LB 0B", rd, 32'h00000011);
      do3(1'b0, 3'd2, 32'(4 * D3), 32'h0, lat, rd, er);
      chk("ws3 oor latency", 32'(lat), 32'd4);
      chk("ws3 oor err", {31'd0, er}, 32'd1);
      chk("ws3 oor rdata", rd, 32'd0);
      repeat (2) @(negedge clk);
      cmp_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
